class_valmem_arb: RTL and testbench

//  Two-requester arbiter and sequencer for classifier value memory port B
//  (UltraRAM, 320b x 32k).

---
 rtl/class_valmem_arb.sv | 124 ++++++++++++
 tb/tb_class_valmem_arb.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/class_valmem_arb.sv
// Round-robin arbiter/sequencer sharing value memory port B between PIO and the insert/remove engine.
// Write ack at t+2, read ack at t+2+RD_LAT; requests wait (held level) while another access is outstanding.
module class_valmem_arb #(
  parameter int AW     = 15,
  parameter int DW     = 320,
  parameter int RD_LAT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pio_req,
  input  logic          pio_wr,
  input  logic [AW-1:0] pio_addr,
  input  logic [DW-1:0] pio_wdata,
  output logic          pio_ack,
  output logic [DW-1:0] pio_rdata,
  input  logic          eng_req,
  input  logic          eng_wr,
  input  logic [AW-1:0] eng_addr,
  input  logic [DW-1:0] eng_wdata,
  output logic          eng_ack,
  output logic [DW-1:0] eng_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t        state;
  logic          gnt_eng;
  logic          rr_last_eng;
  logic          lat_wr;
  logic          mask_pio;
  logic          mask_eng;
  logic [CW-1:0] cnt;

  logic elig_pio;
  logic elig_eng;
  logic pick_eng;

  always_comb begin
    elig_pio = pio_req & ~mask_pio;
    elig_eng = eng_req & ~mask_eng;
    // On a tie the requester that did not win last time gets the port
    pick_eng = elig_eng & (~elig_pio | ~rr_last_eng);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      gnt_eng     <= 1'b0;
      rr_last_eng <= 1'b1;
      lat_wr      <= 1'b0;
      mask_pio    <= 1'b0;
      mask_eng    <= 1'b0;
      cnt         <= '0;
      pio_ack     <= 1'b0;
      eng_ack     <= 1'b0;
      pio_rdata   <= '0;
      eng_rdata   <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
    end else begin
      mem_we   <= 1'b0;
      pio_ack  <= 1'b0;
      eng_ack  <= 1'b0;
      mask_pio <= 1'b0;
      mask_eng <= 1'b0;
      case (state)
        IDLE: begin
          if (elig_pio | elig_eng) begin
            gnt_eng     <= pick_eng;
            rr_last_eng <= pick_eng;
            lat_wr      <= pick_eng ? eng_wr : pio_wr;
            mem_we      <= pick_eng ? eng_wr : pio_wr;
            mem_addr    <= pick_eng ? eng_addr : pio_addr;
            mem_wdata   <= pick_eng ? eng_wdata : pio_wdata;
            busy        <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (lat_wr) begin
            pio_ack <= ~gnt_eng;
            eng_ack <= gnt_eng;
            state   <= ACK;
          end else begin
            cnt   <= CW'(RD_LAT - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            if (gnt_eng) eng_rdata <= mem_rdata;
            else         pio_rdata <= mem_rdata;
            pio_ack <= ~gnt_eng;
            eng_ack <= gnt_eng;
            state   <= ACK;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ACK: begin
          // Requester still shows req in the next cycle; keep it from being regranted
          mask_pio <= ~gnt_eng;
          mask_eng <= gnt_eng;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_class_valmem_arb.sv
// Directed bench for class_valmem_arb with a pipelined port-B memory model.
module tb_class_valmem_arb #(
  parameter int AW     = 15,
  parameter int DW     = 320,
  parameter int RD_LAT = 4
);

  localparam logic [DW-1:0] D_A5   = {(DW/8){8'hA5}};
  localparam logic [DW-1:0] D_DEAD = {(DW/16){16'hDEAD}};
  localparam logic [DW-1:0] D_BEEF = {(DW/16){16'hBEEF}};
  localparam logic [AW-1:0] A_PW   = AW'(15'h0123);
  localparam logic [AW-1:0] A_ER   = AW'(15'h7FF8);
  localparam logic [AW-1:0] A_PR   = AW'(15'h0456);
  localparam logic [AW-1:0] A_EW   = AW'(15'h0200);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pio_req, pio_wr, pio_ack;
  logic [AW-1:0] pio_addr;
  logic [DW-1:0] pio_wdata, pio_rdata;
  logic          eng_req, eng_wr, eng_ack;
  logic [AW-1:0] eng_addr;
  logic [DW-1:0] eng_wdata, eng_rdata;
  logic          mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [DW-1:0] pipe [RD_LAT];

  always #5 clk = ~clk;

  class_valmem_arb #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .pio_req(pio_req), .pio_wr(pio_wr), .pio_addr(pio_addr), .pio_wdata(pio_wdata),
    .pio_ack(pio_ack), .pio_rdata(pio_rdata),
    .eng_req(eng_req), .eng_wr(eng_wr), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
    .eng_ack(eng_ack), .eng_rdata(eng_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  // Read data appears RD_LAT cycles after the address is presented
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] = mem_wdata;
    pipe[0] <= mem.exists(mem_addr) ? mem[mem_addr] : '0;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[RD_LAT-1];

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : '0;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    pio_req = 1'b0; pio_wr = 1'b0; pio_addr = '0; pio_wdata = '0;
    eng_req = 1'b0; eng_wr = 1'b0; eng_addr = '0; eng_wdata = '0;
    mem[A_ER] = D_DEAD;
    mem[A_PR] = D_BEEF;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_pio_ack", pio_ack, 0);
    chk("rst_eng_ack", eng_ack, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_pio_rdata", pio_rdata, 0);
    chk("rst_eng_rdata", eng_rdata, 0);
    rst_n = 1'b1;
    step();

    // PIO write: mem_we at t+1, ack at t+2
    pio_wr = 1'b1; pio_addr = A_PW; pio_wdata = D_A5; pio_req = 1'b1;
    step();
    chk("t1_we", mem_we, 1);
    chk("t1_addr", mem_addr, A_PW);
    chk("t1_wdata", mem_wdata, D_A5);
    chk("t1_busy", busy, 1);
    chk("t1_ack_early", pio_ack, 0);
    step();
    chk("t1_ack", pio_ack, 1);
    chk("t1_eng_ack", eng_ack, 0);
    chk("t1_we_off", mem_we, 0);
    pio_req = 1'b0;
    step();
    chk("t1_ack_single", pio_ack, 0);
    chk("t1_idle", busy, 0);
    chk("t1_mem", mem_rd(A_PW), D_A5);

    // Engine read: ack at t+2+RD_LAT
    eng_wr = 1'b0; eng_addr = A_ER; eng_req = 1'b1;
    for (int i = 1; i <= 2 + RD_LAT; i++) begin
      step();
      chk($sformatf("t2_eng_ack_%0d", i), eng_ack, (i == 2 + RD_LAT));
      chk($sformatf("t2_pio_ack_%0d", i), pio_ack, 0);
      chk($sformatf("t2_we_%0d", i), mem_we, 0);
    end
    chk("t2_eng_rdata", eng_rdata, D_DEAD);
    chk("t2_pio_rdata", pio_rdata, 0);
    eng_req = 1'b0;
    step();

    // Both held: writes alternate PIO, ENG, PIO, ENG
    pio_wr = 1'b1; pio_addr = AW'(15'h0010); pio_wdata = D_A5;
    eng_wr = 1'b1; eng_addr = AW'(15'h0020); eng_wdata = D_A5;
    pio_req = 1'b1; eng_req = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      step();
      chk($sformatf("t3_pio_ack_%0d", i), pio_ack, (i == 2 || i == 8));
      chk($sformatf("t3_eng_ack_%0d", i), eng_ack, (i == 5 || i == 11));
      if (i == 1) chk("t3_first_addr", mem_addr, AW'(15'h0010));
      if (i == 4) chk("t3_second_addr", mem_addr, AW'(15'h0020));
      if (i == 11) begin
        pio_req = 1'b0; eng_req = 1'b0;
      end
    end
    step(); step();

    // Engine streams 3 writes while a PIO read waits
    eng_wr = 1'b1; eng_addr = A_EW; eng_wdata = {(DW/8){8'h10}}; eng_req = 1'b1;
    pio_wr = 1'b0; pio_addr = A_PR;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk($sformatf("t4_pio_ack_%0d", i), pio_ack, (i == 9));
      chk($sformatf("t4_eng_ack_%0d", i), eng_ack, (i == 2 || i == 12 || i == 16));
      if (i == 1) pio_req = 1'b1;
      if (i == 9) pio_req = 1'b0;
      if (i == 2) begin
        eng_addr = A_EW + AW'(1); eng_wdata = {(DW/8){8'h11}};
      end
      if (i == 12) begin
        eng_addr = A_EW + AW'(2); eng_wdata = {(DW/8){8'h12}};
      end
      if (i == 16) eng_req = 1'b0;
    end
    chk("t4_pio_rdata", pio_rdata, D_BEEF);
    chk("t4_eng_rdata", eng_rdata, D_DEAD);
    chk("t4_mem0", mem_rd(A_EW), {(DW/8){8'h10}});
    chk("t4_mem1", mem_rd(A_EW + AW'(1)), {(DW/8){8'h11}});
    chk("t4_mem2", mem_rd(A_EW + AW'(2)), {(DW/8){8'h12}});
    step();

    // Reset during WAIT of a PIO read
    pio_wr = 1'b0; pio_addr = A_PR; pio_req = 1'b1;
    step();
    chk("t5_issue_busy", busy, 1);
    step();
    rst_n = 1'b0; pio_req = 1'b0;
    step();
    chk("t5_busy", busy, 0);
    chk("t5_pio_ack", pio_ack, 0);
    chk("t5_pio_rdata", pio_rdata, 0);
    chk("t5_eng_rdata", eng_rdata, 0);
    chk("t5_mem_addr", mem_addr, 0);
    chk("t5_mem_we", mem_we, 0);
    chk("t5_mem_wdata", mem_wdata, 0);
    step();
    chk("t5_no_ack", pio_ack, 0);
    rst_n = 1'b1;
    step();
    eng_wr = 1'b0; eng_addr = A_ER; eng_req = 1'b1;
    for (int i = 1; i <= 2 + RD_LAT; i++) begin
      step();
      chk($sformatf("t5_eng_ack_%0d", i), eng_ack, (i == 2 + RD_LAT));
      chk($sformatf("t5_pio_ack_%0d", i), pio_ack, 0);
    end
    chk("t5_eng_rdata_after", eng_rdata, D_DEAD);
    eng_req = 1'b0;
    step();
    chk("t5_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
